// File: rtl/bip_pkg.sv
// Shared BIP definitions: opcode field width, the HLT opcode and the fetch FSM state codes.
package bip_pkg;

   localparam int OPCODE_LEN = 5;
   localparam logic [OPCODE_LEN-1:0] OP_HLT = 5'b00000;

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_RUN  = 2'b01;
   localparam logic [1:0] ST_HALT = 2'b10;

endpackage

// File: rtl/bip_cycle_counter.sv
// Saturating execution-cycle counter: clear has priority over inc, and the count sticks at all-ones.
module bip_cycle_counter #(
   parameter int count_len = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clear,
   input  logic                 inc,
   output logic [count_len-1:0] count
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + count_len'(1);
      end
   end

endmodule

// File: rtl/bip_pc_fetch.sv
// BIP program counter and fetch sequencer: steps the PC via the PC adder, stops on HLT and
// counts RUN cycles for the debug unit.
//
//   state | meaning
//   IDLE  | after reset, waiting for start, pc held at 0
//   RUN   | executing one instruction per cycle
//   HALT  | HLT fetched, pc and cycle count frozen until start
module bip_pc_fetch
   import bip_pkg::*;
#(
   parameter int len        = 16,
   parameter int inst_len   = 16,
   parameter int opcode_len = OPCODE_LEN,
   parameter int count_len  = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [len-1:0]       adder_out,
   input  logic [inst_len-1:0]  instruction,
   output logic [len-1:0]       pc,
   output logic                 run,
   output logic                 halted,
   output logic [count_len-1:0] cycle_count
);

   logic [1:0]            state;
   logic [1:0]            state_nxt;
   logic [opcode_len-1:0] opcode;
   logic                  is_hlt;
   logic                  launch;
   logic                  unused_operand;

   assign opcode         = instruction[inst_len-1 -: opcode_len];
   assign is_hlt         = (opcode == opcode_len'(OP_HLT));
   assign unused_operand = ^instruction[inst_len-opcode_len-1:0];

   // A new program may be launched from IDLE or HALT; start is ignored in RUN.
   assign launch = start && (state != ST_RUN);

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (start)  state_nxt = ST_RUN;
         ST_RUN:  if (is_hlt) state_nxt = ST_HALT;
         ST_HALT: if (start)  state_nxt = ST_RUN;
         default:             state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // The HLT fetch leaves pc pointing at the HLT instruction.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc <= '0;
      end else if (launch) begin
         pc <= '0;
      end else if ((state == ST_RUN) && !is_hlt) begin
         pc <= adder_out;
      end
   end

   assign run    = (state == ST_RUN);
   assign halted = (state == ST_HALT);

   bip_cycle_counter #(
      .count_len (count_len)
   ) u_cycle_counter (
      .clk   (clk),
      .reset (reset),
      .clear (launch),
      .inc   (state == ST_RUN),
      .count (cycle_count)
   );

endmodule

// File: tb/tb_bip_pc_fetch.sv
// Self-checking bench for bip_pc_fetch: directed scenarios plus random programs against a
// behavioural model, and a narrow instance for PC wrap and counter saturation.
module tb_bip_pc_fetch;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        start_s;
   logic [15:0] pc, adder_out, instruction;
   logic        run, halted;
   logic [31:0] cycle_count;
   logic [3:0]  pc_s, adder_out_s, cycle_count_s;
   logic [15:0] instruction_s;
   logic        run_s, halted_s;

   logic [15:0] mem [0:255];
   int checks = 0;
   int failures = 0;

   // behavioural model of the main instance
   bit          m_run, m_halt;
   logic [15:0] m_pc;
   logic [31:0] m_cnt;

   always #5 clk = ~clk;

   assign adder_out     = pc + 16'd1;
   assign instruction   = mem[pc[7:0]];
   assign adder_out_s   = pc_s + 4'd1;
   assign instruction_s = 16'h8123;

   bip_pc_fetch dut (
      .clk(clk), .reset(reset), .start(start), .adder_out(adder_out),
      .instruction(instruction), .pc(pc), .run(run), .halted(halted),
      .cycle_count(cycle_count)
   );

   bip_pc_fetch #(.len(4), .inst_len(16), .opcode_len(5), .count_len(4)) dut_s (
      .clk(clk), .reset(reset), .start(start_s), .adder_out(adder_out_s),
      .instruction(instruction_s), .pc(pc_s), .run(run_s), .halted(halted_s),
      .cycle_count(cycle_count_s)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_run = 0; m_halt = 0; m_pc = '0; m_cnt = '0;
   endtask

   task automatic compare_main(input string tag);
      check({tag, "_pc"}, 64'(pc), 64'(m_pc));
      check({tag, "_run"}, 64'(run), 64'(m_run));
      check({tag, "_halted"}, 64'(halted), 64'(m_halt));
      check({tag, "_count"}, 64'(cycle_count), 64'(m_cnt));
   endtask

   // Advance the model by one edge using the inputs present now, then sample after the edge.
   task automatic step(input string tag);
      logic [15:0] word;
      word = mem[m_pc[7:0]];
      if (reset) begin
         model_reset();
      end else if (m_run) begin
         if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
         if (word[15:11] == 5'd0) begin
            m_run = 0; m_halt = 1;
         end else begin
            m_pc = m_pc + 16'd1;
         end
      end else if (start) begin
         m_run = 1; m_halt = 0; m_pc = '0; m_cnt = '0;
      end
      @(posedge clk);
      #1;
      compare_main(tag);
   endtask

   task automatic load_program(input int h);
      for (int i = 0; i < 256; i++)
         mem[i] = {5'($urandom_range(1, 31)), 11'($urandom)};
      if (h < 256) mem[h] = {5'd0, 11'($urandom)};
   endtask

   task automatic run_program(input int h, input int hold, input int poke);
      int halt_at;
      load_program(h);
      start = 1'b1;
      halt_at = -1;
      for (int idx = 0; idx < h + 6; idx++) begin
         if (idx >= hold) start = (poke >= 0 && m_run && m_pc == 16'(poke)) ? 1'b1 : 1'b0;
         step("prog");
         if (halted === 1'b1 && halt_at < 0) halt_at = idx;
         if (m_halt) break;
      end
      start = 1'b0;
      check("halt_edge", 64'(halt_at), 64'(h + 1));
      check("final_pc", 64'(pc), 64'(h));
      check("final_count", 64'(cycle_count), 64'(h + 1));
      check("final_run", 64'(run), 64'd0);
   endtask

   initial begin
      logic [3:0] sp, sc;
      int h, hold;
      reset = 1'b1; start = 1'b0; start_s = 1'b0;
      model_reset();
      load_program(300);
      #12;
      compare_main("reset");
      check("reset_s_pc", 64'(pc_s), 64'd0);
      check("reset_s_count", 64'(cycle_count_s), 64'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      // reset mid-RUN at pc=5
      load_program(20);
      start = 1'b1;
      step("mid_start");
      start = 1'b0;
      for (int i = 0; i < 10 && m_pc != 16'd5; i++) step("mid_run");
      check("mid_pc_before", 64'(pc), 64'd5);
      #2 reset = 1'b1;
      #1;
      model_reset();
      compare_main("async_reset");
      #1 reset = 1'b0;
      for (int i = 0; i < 3; i++) step("idle_wait");

      run_program(3, 1, -1);
      run_program(1, 1, -1);
      run_program(0, 1, -1);
      run_program(6, 3, 2);

      for (int n = 0; n < 12; n++) begin
         h = $urandom_range(0, 30);
         hold = $urandom_range(1, (h + 1 < 3) ? h + 1 : 3);
         run_program(h, hold, (($urandom_range(0, 1) == 1) && h > 1) ? $urandom_range(0, h - 1) : -1);
         for (int i = 0; i < $urandom_range(0, 2); i++) step("halt_hold");
      end

      // narrow instance: pc wraps at 4 bits, count saturates at 15
      start_s = 1'b1;
      @(posedge clk); #1;
      start_s = 1'b0;
      sp = 4'd0; sc = 4'd0;
      check("s_start_pc", 64'(pc_s), 64'(sp));
      check("s_start_run", 64'(run_s), 64'd1);
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         sp = sp + 4'd1;
         if (sc != 4'hF) sc = sc + 4'd1;
         check("s_pc", 64'(pc_s), 64'(sp));
         check("s_run", 64'(run_s), 64'd1);
         check("s_count", 64'(cycle_count_s), 64'(sc));
      end
      check("s_saturated", 64'(cycle_count_s), 64'd15);
      check("s_halted", 64'(halted_s), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
